stream_mux_arb: RTL and testbench

- Parametrised N-input, valid/ready streaming multiplexer with a registered output stage.
- Two selection modes:
  - Fixed select: a direct, generalised replacement for the processor's fixed 5:1 datapath muxes.
  - Round-robin arbitration: used where several producers share one consumer (e.g. cache-refill or context-switch save paths).
- One result per cycle sustained; output stalls cleanly under backpressure.

---
 rtl/stream_mux_arb.sv | 92 +++++++++
 tb/tb_stream_mux_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// N-input valid/ready stream mux (fixed select or round-robin) with a registered output; 1-cycle latency.
// Backpressure: a held word stalls all inputs; drain and reload happen in the same cycle.
module stream_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 5,
    parameter int SEL_W = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N_IN);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

    logic [WIDTH-1:0] ch_data [N_IN];
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] fx_idx;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W:0]   cand;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;

    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Out-of-range selects fold onto the last channel.
    assign fx_idx = ({1'b0, select} < N_EXT) ? select : LAST_IDX;

    // Search starts one past the last winner; one extra bit keeps the sum from wrapping before the modulo.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= N_IN; k++) begin
            cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!rr_found && in_valid[cand[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SEL_W-1:0];
            end
        end
    end

    assign grant     = mode ? rr_idx : fx_idx;
    assign grant_vld = mode ? rr_found : 1'b1;
    assign load_en   = !out_valid || out_ready;
    assign xfer      = load_en && grant_vld && in_valid[grant] && !RESET;

    always_comb begin
        in_ready = '0;
        if (load_en && grant_vld && !RESET) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= LAST_IDX;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
            end
            // Data and source only move on a real transfer; a drain without reload keeps them.
            if (xfer) begin
                out_data <= ch_data[grant];
                out_src  <= grant;
                if (mode) begin
                    rr_ptr <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Randomised and directed bench for stream_mux_arb against a queue-free behavioural model.
module tb_stream_mux_arb;

    localparam int W = 32;
    localparam int N = 5;
    localparam int S = 3;

    logic           CLK;
    logic           RESET;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [S-1:0]   select;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [S-1:0]   out_src;

    logic [W-1:0] d [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_rr;
    logic [N-1:0] seen_ready;

    stream_mux_arb #(.WIDTH(W), .N_IN(N), .SEL_W(S)) dut (
        .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_grant(output int g, output bit ok);
        g  = 0;
        ok = 0;
        if (!mode) begin
            g  = (int'(select) < N) ? int'(select) : N - 1;
            ok = 1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!ok && in_valid[c]) begin
                    ok = 1;
                    g  = c;
                end
            end
        end
    endtask

    // Inputs are set by the caller at a negedge; checks ready, clocks once, checks outputs at next negedge.
    task automatic step();
        int           g;
        bit           ok;
        bit           load;
        logic [N-1:0] exp_rdy;
        #1;
        model_grant(g, ok);
        load    = !m_valid || out_ready;
        exp_rdy = '0;
        if (!RESET && load && ok) exp_rdy[g] = 1'b1;
        seen_ready = in_ready;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge CLK);
        if (RESET) begin
            m_valid = 0; m_data = '0; m_src = 0; m_rr = N - 1;
        end else if (load && ok && in_valid[g]) begin
            m_valid = 1; m_data = d[g]; m_src = g;
            if (mode) m_rr = g;
        end else if (load) begin
            m_valid = 0;
        end
        @(negedge CLK);
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_src", 64'(out_src), 64'(m_src));
    endtask

    initial begin
        RESET = 1; mode = 0; select = '0; in_valid = '0; out_ready = 1;
        for (int i = 0; i < N; i++) d[i] = '0;
        m_valid = 0; m_data = '0; m_src = 0; m_rr = N - 1;

        // Reset state
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_ready", 64'(seen_ready), 64'd0);
        RESET = 0;

        // Fixed select
        mode = 0; select = 3'd2; d[2] = 32'hA5A5_0002; in_valid = 5'b00100;
        step();
        check("fix_ready", 64'(seen_ready), 64'b00100);
        check("fix_valid", 64'(out_valid), 64'd1);
        check("fix_data", 64'(out_data), 64'hA5A5_0002);
        check("fix_src", 64'(out_src), 64'd2);

        // Out-of-range select maps to last channel
        select = 3'd7; d[4] = 32'h44; in_valid = 5'b10000;
        step();
        check("oor_data", 64'(out_data), 64'h44);
        check("oor_src", 64'(out_src), 64'd4);

        // Round-robin fairness from reset pointer
        mode = 1; in_valid = 5'b11111;
        for (int i = 0; i < N; i++) d[i] = 32'h10 + 32'(i);
        for (int c = 0; c < 10; c++) begin
            step();
            check("rr_src", 64'(out_src), 64'(c % N));
            check("rr_valid", 64'(out_valid), 64'd1);
        end

        // Backpressure: word with src 4 / data 0x14 is held
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            d[1] = $urandom;
            step();
            check("bp_data", 64'(out_data), 64'h14);
            check("bp_ready", 64'(seen_ready), 64'd0);
        end
        out_ready = 1; d[1] = 32'h11;
        step();
        check("bp_reload_src", 64'(out_src), 64'd0);
        check("bp_reload_valid", 64'(out_valid), 64'd1);

        // Sparse round-robin with wrap: park pointer on ch3 first
        in_valid = 5'b01000;
        step();
        check("sp_src3", 64'(out_src), 64'd3);
        in_valid = 5'b01010;
        step(); check("sp_src_a", 64'(out_src), 64'd1);
        step(); check("sp_src_b", 64'(out_src), 64'd3);
        step(); check("sp_src_c", 64'(out_src), 64'd1);
        in_valid = '0;
        step();
        check("sp_empty_valid", 64'(out_valid), 64'd0);
        check("sp_hold_src", 64'(out_src), 64'd1);

        // Reset mid-stream while a word is held
        in_valid = 5'b11111;
        step();
        out_ready = 0;
        step();
        check("mr_held", 64'(out_valid), 64'd1);
        RESET = 1;
        step();
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_data", 64'(out_data), 64'd0);
        check("mr_src", 64'(out_src), 64'd0);
        check("mr_ready", 64'(seen_ready), 64'd0);
        RESET = 0; out_ready = 1; in_valid = 5'b00110;
        step();
        check("mr_first_grant", 64'(out_src), 64'd1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            RESET     = ($urandom_range(0, 99) < 2);
            mode      = 1'($urandom);
            select    = S'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) d[i] = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
